// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a byte as start, 8 data bits LSB-first,
// parity and stop, and drives the TX output mux select, data bit and parity.
module uart_tx_ctrl #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TxStart,
  input  logic [7:0] TxDataIn,
  input  logic       ParityType,
  output logic [1:0] sel,
  output logic       PISO,
  output logic       ParityGen,
  output logic       TxBusy,
  output logic       TxDone
);

  localparam int             CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_baud;
  logic [CNT_W-1:0] w_baud_nxt;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_par;
  logic             w_par_nxt;
  logic [1:0]       r_sel;
  logic             r_busy;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_tick;

  function automatic logic [1:0] sel_decode(input state_t s);
    case (s)
      S_START:  sel_decode = 2'b00;
      S_DATA:   sel_decode = 2'b01;
      S_PARITY: sel_decode = 2'b10;
      default:  sel_decode = 2'b11;
    endcase
  endfunction

  always_comb begin
    w_tick      = (r_state != S_IDLE) && (r_baud == LAST_CNT);
    w_state_nxt = r_state;
    w_baud_nxt  = (r_state == S_IDLE) ? r_baud : (w_tick ? '0 : r_baud + 1'b1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (TxStart) begin
          w_shift_nxt = TxDataIn;
          w_par_nxt   = (^TxDataIn) ^ ParityType;
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        // Ones shift in so PISO rests high once the byte has been sent
        if (w_tick) begin
          w_shift_nxt = {1'b1, r_shift[7:1]};
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_tick) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_tick) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'hFF;
      r_par   <= 1'b0;
      r_sel   <= 2'b11;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_sel   <= sel_decode(w_state_nxt);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign sel       = r_sel;
  assign PISO      = r_shift[0];
  assign ParityGen = r_par;
  assign TxBusy    = r_busy;
  assign TxDone    = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: per-cycle expected outputs are queued when a frame
// is started and compared one entry per clock against two instances.
module tb_uart_tx_ctrl;

  typedef struct packed {
    logic [1:0] sel;
    logic       piso;
    logic       par;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st4, pt4, st2, pt2;
  logic [7:0] d4, d2;
  logic [1:0] sel4, sel2;
  logic       piso4, par4, busy4, done4;
  logic       piso2, par2, busy2, done2;

  obs_t exp_q[$];
  int   n_err = 0;
  int   n_chk = 0;
  logic lpar4 = 1'b0;
  logic lpar2 = 1'b0;

  uart_tx_ctrl #(.BAUD_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .TxStart(st4), .TxDataIn(d4), .ParityType(pt4),
    .sel(sel4), .PISO(piso4), .ParityGen(par4), .TxBusy(busy4), .TxDone(done4)
  );

  uart_tx_ctrl #(.BAUD_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .TxStart(st2), .TxDataIn(d2), .ParityType(pt2),
    .sel(sel2), .PISO(piso2), .ParityGen(par2), .TxBusy(busy2), .TxDone(done2)
  );

  function automatic obs_t observe(input int w);
    obs_t o;
    if (w == 4) o = {sel4, piso4, par4, busy4, done4};
    else        o = {sel2, piso2, par2, busy2, done2};
    return o;
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] d, input logic pt);
    if (w == 4) begin st4 = s; d4 = d; pt4 = pt; end
    else        begin st2 = s; d2 = d; pt2 = pt; end
  endtask

  // Reference frame: bit slot b = k/div; slot 0 start, 1..8 data, 9 parity, 10 stop
  task automatic push_frame(input int div, input logic [7:0] d, input logic pt,
                            output logic par);
    obs_t e;
    int   b;
    par = (^d) ^ pt;
    for (int k = 0; k < 11 * div; k++) begin
      b      = k / div;
      e.busy = 1'b1;
      e.done = 1'b0;
      e.par  = par;
      if (b == 0)      begin e.sel = 2'b00; e.piso = d[0];   end
      else if (b <= 8) begin e.sel = 2'b01; e.piso = d[b-1]; end
      else if (b == 9) begin e.sel = 2'b10; e.piso = 1'b1;   end
      else             begin e.sel = 2'b11; e.piso = 1'b1;   end
      exp_q.push_back(e);
    end
    e = {2'b11, 1'b1, par, 1'b0, 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input logic par, input int n);
    obs_t e;
    e = {2'b11, 1'b1, par, 1'b0, 1'b0};
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic check_now(input int w, input string tag);
    obs_t got, e;
    got = observe(w);
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got %b but scoreboard had no expected entry", tag, got);
    end else begin
      e = exp_q.pop_front();
      assert (got === e) else begin
        n_err++;
        $error("FAIL %s: got sel=%b piso=%b par=%b busy=%b done=%b, expected sel=%b piso=%b par=%b busy=%b done=%b",
               tag, got.sel, got.piso, got.par, got.busy, got.done,
               e.sel, e.piso, e.par, e.busy, e.done);
      end
    end
  endtask

  task automatic step(input int w, input string tag);
    @(posedge clk);
    #1;
    check_now(w, tag);
  endtask

  task automatic run(input int w, input int n, input string tag);
    repeat (n) step(w, tag);
  endtask

  // Full frame plus one idle cycle; inputs are scrambled right after accept
  task automatic send(input int w, input logic [7:0] d, input logic pt, input string tag);
    int   div;
    logic p;
    div = (w == 4) ? 4 : 2;
    drive(w, 1'b1, d, pt);
    push_frame(div, d, pt, p);
    step(w, tag);
    drive(w, 1'b0, ~d, ~pt);
    run(w, 11 * div, tag);
    if (w == 4) lpar4 = p; else lpar2 = p;
    push_idle(p, 1);
    step(w, {tag, "_idle"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p;
    rst = 1'b1;
    drive(4, 1'b0, 8'h00, 1'b0);
    drive(2, 1'b0, 8'h00, 1'b0);
    #2;
    push_idle(1'b0, 1);
    check_now(4, "reset4");
    push_idle(1'b0, 1);
    check_now(2, "reset2");
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_idle(1'b0, 2);
    run(4, 2, "idle4");

    send(4, 8'hA5, 1'b0, "a5_even");
    send(4, 8'hA5, 1'b1, "a5_odd");
    send(4, 8'h07, 1'b0, "x07_even");

    // Start requests mid-frame must be ignored
    drive(4, 1'b1, 8'h5A, 1'b0);
    push_frame(4, 8'h5A, 1'b0, p);
    step(4, "ignore");
    drive(4, 1'b0, 8'h00, 1'b0);
    run(4, 4, "ignore");
    drive(4, 1'b1, 8'hFF, 1'b1);
    step(4, "ignore");
    drive(4, 1'b0, 8'h00, 1'b0);
    run(4, 14, "ignore");
    drive(4, 1'b1, 8'hFF, 1'b1);
    step(4, "ignore");
    drive(4, 1'b0, 8'h00, 1'b0);
    run(4, 24, "ignore");
    push_idle(p, 2);
    run(4, 2, "ignore_idle");

    // Back-to-back: start held through the TxDone cycle
    drive(4, 1'b1, 8'hA5, 1'b0);
    push_frame(4, 8'hA5, 1'b0, p);
    step(4, "b2b_f1");
    drive(4, 1'b0, 8'h00, 1'b0);
    run(4, 39, "b2b_f1");
    drive(4, 1'b1, 8'h3C, 1'b0);
    push_frame(4, 8'h3C, 1'b0, p);
    run(4, 5, "b2b_f1_end");
    step(4, "b2b_f2");
    drive(4, 1'b0, 8'h00, 1'b0);
    run(4, 44, "b2b_f2");
    push_idle(p, 1);
    step(4, "b2b_idle");

    // Asynchronous reset during data bit 3
    drive(4, 1'b1, 8'h96, 1'b0);
    push_frame(4, 8'h96, 1'b0, p);
    step(4, "rst_frame");
    drive(4, 1'b0, 8'h00, 1'b0);
    run(4, 17, "rst_frame");
    exp_q.delete();
    #2;
    rst = 1'b1;
    #1;
    push_idle(1'b0, 1);
    check_now(4, "rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_idle(1'b0, 3);
    run(4, 3, "post_rst_idle");
    send(4, 8'hC3, 1'b1, "post_rst_frame");

    send(2, 8'hFF, 1'b0, "div2_ff");

    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL queue_drained: got %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side controller for the UART. It sits directly upstream of the TX output multiplexer and drives the mux's `sel`, `PISO` and `ParityGen` inputs. It accepts a byte on a start strobe and times each frame bit with an internal baud divider. The frame is start, 8 data bits LSB-first, parity, then stop.

## Interface
- `BAUD_DIV`, default 5208: clock cycles per bit (50 MHz / 9600 baud). Legal range ≥ 2.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `TxStart`  input  1  request to send `TxDataIn`; sampled only in IDLE.
- `TxDataIn`  input  8  byte to transmit.
- `ParityType`  input  1  0 = even parity, 1 = odd parity; sampled with `TxStart`.
- `sel`  output  2  mux select: 00 start, 01 data, 10 parity, 11 stop/idle.
- `PISO`  output  1  current data bit (LSB of internal shift register).
- `ParityGen`  output  1  parity bit of the latched byte.
- `TxBusy`  output  1  high while a frame is in progress.
- `TxDone`  output  1  one-cycle pulse on frame completion.

## Operation
- Clocking and reset: one clock; reset is asynchronous and active-high.
- States: IDLE, START, DATA, PARITY, STOP.
- `sel` per state: IDLE = 11, START = 00, DATA = 01, PARITY = 10, STOP = 11. `sel` is registered and is a direct decode of the state.
- Accept: in IDLE with `TxStart` = 1, on the rising edge:
  - latch `TxDataIn` into an 8-bit shift register;
  - latch `ParityGen` = ^`TxDataIn` XOR `ParityType`;
  - clear the baud counter and the bit counter;
  - go to START.
- `TxStart` outside IDLE is ignored. No queueing.
- Baud counter: width $clog2(BAUD_DIV). It counts 0..BAUD_DIV-1 in every non-IDLE state. The cycle with counter = BAUD_DIV-1 is the bit-end tick, and the counter wraps to 0 on that cycle.
- Transitions, on the bit-end tick only:
  - START → DATA;
  - DATA: shift register shifts right (MSB filled with 1) and the 3-bit bit counter increments. When the bit counter = 7, go to PARITY instead;
  - PARITY → STOP;
  - STOP → IDLE.
- `PISO` = shift register bit 0 at all times. In DATA it presents data bits 0..7 in order.
- `TxBusy` = 1 in every state except IDLE.
- `TxDone` = 1 for exactly the first IDLE cycle after STOP. The same cycle is a legal accept cycle, so back-to-back frames carry no idle gap.
- `ParityGen` holds its latched value until the next accept.

## Timing
- Reset values: `sel` = 11, `PISO` = 1, `ParityGen` = 0, `TxBusy` = 0, `TxDone` = 0, state = IDLE, all counters 0.
- Reset asserted mid-frame forces these values immediately, without waiting for a clock edge. The frame is abandoned and no `TxDone` is produced.
- Latency: `TxStart` sampled at edge N gives `sel` = 00 and `TxBusy` = 1 from edge N.
- Each bit lasts exactly BAUD_DIV cycles.
- Frame length is 11 × BAUD_DIV cycles, from the accept edge to the edge that returns the block to IDLE. `TxDone` is high during the following cycle.
- Outputs change only on clock edges (registered) or on asynchronous reset. Nothing is combinational from the inputs.
- Changes to `TxDataIn` or `ParityType` after accept have no effect on the frame in progress.

## Test plan
- BAUD_DIV = 4. Send 0xA5 with even parity:
  - `sel` sequence is 00 ×4 cycles, 01 ×32, 10 ×4, 11;
  - `PISO` across DATA is 1,0,1,0,0,1,0,1, 4 cycles each;
  - `ParityGen` = 0;
  - `TxDone` pulses once, 44 cycles after accept.
- Same byte 0xA5 with `ParityType` = 1 → `ParityGen` = 1. Send 0x07 with even parity → `ParityGen` = 1.
- Pulse `TxStart` again at cycles 5 and 20 of a frame with a different byte → frame unchanged, exactly one `TxDone`.
- Hold `TxStart` high with 0x3C across the `TxDone` cycle → second frame's START begins on the next cycle with zero idle gap. Its `PISO` bits are 0,0,1,1,1,1,0,0.
- Assert `rst` for 1 cycle during DATA bit 3 → `sel` = 11, `TxBusy` = 0, `PISO` = 1 immediately, with no `TxDone`. A new `TxStart` after reset sends a complete, correct frame.
- BAUD_DIV = 2 (minimum) with 0xFF, even parity → each bit 2 cycles, `ParityGen` = 0, frame 22 cycles.
